// File: rtl/test_i15423_pkg.sv
// Shared types, default parameters and the core Boolean function for the
// test_i15423 registered logic cell.
package test_i15423_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ARMED = 2'd2
    } mon_state_t;

    localparam logic [3:0]  DEF_TRIG_PATTERN = 4'b1111;
    localparam int unsigned DEF_TRIG_LEN     = 4;

    // Bit 3 is N0 (MSB of the sampled vector), bit 0 is N3.
    function automatic logic core_f(input logic [3:0] n);
        return (n[3] ^ n[2]) | (n[1] & n[0]);
    endfunction

endpackage

// File: rtl/test_i15423_if.sv
// Pin bundle of the test_i15423 cell: four data inputs and the registered output.
interface test_i15423_if;

    logic N0;
    logic N1;
    logic N2;
    logic N3;
    logic Y;

    modport master (output N0, output N1, output N2, output N3, input Y);
    modport slave  (input N0, input N1, input N2, input N3, output Y);

endinterface

// File: rtl/test_i15423_monitor.sv
// Pattern-run monitor: counts consecutive matching samples and latches a sticky
// armed flag once TRIG_LEN of them have been seen in a row.
module test_i15423_monitor
    import test_i15423_pkg::*;
#(
    parameter int unsigned TRIG_LEN = DEF_TRIG_LEN
) (
    input  logic CK,
    input  logic reset,
    input  logic match,
    output logic armed
);

    localparam logic [3:0] LEN_C = 4'(TRIG_LEN);

    mon_state_t state_r;
    logic [2:0] cnt_r;
    logic       armed_r;
    logic [3:0] cnt_inc_s;

    assign cnt_inc_s = {1'b0, cnt_r} + 4'd1;
    assign armed     = armed_r;

    // Monitor FSM with run counter; armed_r mirrors state_r == ARMED.
    always_ff @(posedge CK) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            armed_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (match) begin
                        cnt_r <= 3'd1;
                        if (LEN_C == 4'd1) begin
                            state_r <= ARMED;
                            armed_r <= 1'b1;
                        end else begin
                            state_r <= COUNT;
                            armed_r <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 3'd0;
                        armed_r <= 1'b0;
                    end
                end
                COUNT: begin
                    if (match) begin
                        cnt_r <= cnt_inc_s[2:0];
                        if (cnt_inc_s == LEN_C) begin
                            state_r <= ARMED;
                            armed_r <= 1'b1;
                        end else begin
                            state_r <= COUNT;
                            armed_r <= 1'b0;
                        end
                    end else begin
                        // Broken run: a later match restarts counting from 1.
                        state_r <= IDLE;
                        cnt_r   <= 3'd0;
                        armed_r <= 1'b0;
                    end
                end
                ARMED: begin
                    state_r <= ARMED;
                    cnt_r   <= cnt_r;
                    armed_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 3'd0;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/test_i15423.sv
// Registered 4-input logic cell: input register, fixed core function and an
// output register whose value is inverted once the pattern monitor arms.
module test_i15423
    import test_i15423_pkg::*;
#(
    parameter logic [3:0]  TRIG_PATTERN = DEF_TRIG_PATTERN,
    parameter int unsigned TRIG_LEN     = DEF_TRIG_LEN
) (
    input  logic N0,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic CK,
    input  logic reset,
    output logic Y
);

    logic [3:0] n_q_r;
    logic       y_r;
    logic       match_s;
    logic       f_s;
    logic       armed_s;

    assign match_s = (n_q_r == TRIG_PATTERN);
    assign f_s     = core_f(n_q_r);
    assign Y       = y_r;

    test_i15423_monitor #(
        .TRIG_LEN (TRIG_LEN)
    ) u_mon (
        .CK    (CK),
        .reset (reset),
        .match (match_s),
        .armed (armed_s)
    );

    // Input and output registers; armed_s is the monitor state from before this edge.
    always_ff @(posedge CK) begin
        if (reset) begin
            n_q_r <= 4'b0000;
            y_r   <= 1'b0;
        end else begin
            n_q_r <= {N0, N1, N2, N3};
            y_r   <= f_s ^ armed_s;
        end
    end

endmodule

// File: tb/tb_test_i15423.sv
// Randomized and directed bench for test_i15423 (TRIG_LEN=4 and TRIG_LEN=1 builds)
// against a run-length reference model.
module tb_test_i15423;

    logic CK = 1'b0;
    logic reset;

    always #5 CK = ~CK;

    test_i15423_if bus_a ();
    test_i15423_if bus_b ();

    test_i15423 dut (
        .N0    (bus_a.N0),
        .N1    (bus_a.N1),
        .N2    (bus_a.N2),
        .N3    (bus_a.N3),
        .CK    (CK),
        .reset (reset),
        .Y     (bus_a.Y)
    );

    test_i15423 #(
        .TRIG_PATTERN (4'b1111),
        .TRIG_LEN     (1)
    ) dut1 (
        .N0    (bus_b.N0),
        .N1    (bus_b.N1),
        .N2    (bus_b.N2),
        .N3    (bus_b.N3),
        .CK    (CK),
        .reset (reset),
        .Y     (bus_b.Y)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: [0] is the TRIG_LEN=4 build, [1] the TRIG_LEN=1 build.
    int         m_len [2] = '{4, 1};
    logic [3:0] m_nq  [2];
    logic       m_y   [2];
    logic       m_arm [2];
    int         m_run [2];

    // Truth table of the core function, bit index = {N0,N1,N2,N3}.
    logic [15:0] truth_tab = 16'h8FF8;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic logic ref_f(input logic [3:0] v);
        return (v[3] != v[2]) || (v[1] && v[0]);
    endfunction

    task automatic step(input logic [3:0] p, input logic r, input string tag);
        @(negedge CK);
        reset    = r;
        bus_a.N0 = p[3]; bus_a.N1 = p[2]; bus_a.N2 = p[1]; bus_a.N3 = p[0];
        bus_b.N0 = p[3]; bus_b.N1 = p[2]; bus_b.N2 = p[1]; bus_b.N3 = p[0];
        @(posedge CK);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_nq[i]  = 4'b0000;
                m_y[i]   = 1'b0;
                m_run[i] = 0;
                m_arm[i] = 1'b0;
            end else begin
                m_y[i]   = ref_f(m_nq[i]) ^ m_arm[i];
                m_run[i] = (m_nq[i] == 4'b1111) ? m_run[i] + 1 : 0;
                if (m_run[i] >= m_len[i]) m_arm[i] = 1'b1;
                m_nq[i]  = p;
            end
        end
        #1;
        check_eq({tag, "_y"},    bus_a.Y,      m_y[0]);
        check_eq({tag, "_y1"},   bus_b.Y,      m_y[1]);
        check_eq({tag, "_arm"},  dut.armed_s,  m_arm[0]);
        check_eq({tag, "_arm1"}, dut1.armed_s, m_arm[1]);
    endtask

    initial begin
        logic [3:0] v;
        logic       r;
        for (int i = 0; i < 2; i++) begin
            m_nq[i] = 4'b0000; m_y[i] = 1'b0; m_arm[i] = 1'b0; m_run[i] = 0;
        end
        reset = 1'b1;

        step(4'b1111, 1'b1, "rst");
        step(4'b1111, 1'b1, "rst");
        check_eq("rst_y_zero", bus_a.Y, 1'b0);
        check_eq("rst_idle", dut.armed_s, 1'b0);

        // Truth table with a non-matching separator between samples.
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            step(v, 1'b0, "sweep");
            step(4'b0101, 1'b0, "sweep_sep");
            check_eq("truth", bus_a.Y, truth_tab[k]);
        end

        // Near-miss: three matches then a mismatch never arms.
        step(4'b0000, 1'b1, "nm_rst");
        for (int k = 0; k < 3; k++) step(4'b1111, 1'b0, "nm_hold");
        step(4'b0000, 1'b0, "nm_drop");
        step(4'b0000, 1'b0, "nm_drop");
        check_eq("nearmiss_y", bus_a.Y, 1'b0);
        check_eq("nearmiss_arm", dut.armed_s, 1'b0);

        // Arm and check inversion.
        for (int k = 0; k < 6; k++) step(4'b1111, 1'b0, "arm_hold");
        check_eq("armed_set", dut.armed_s, 1'b1);
        step(4'b0000, 1'b0, "arm_0000");
        step(4'b0000, 1'b0, "arm_0000");
        check_eq("arm_y_0000", bus_a.Y, 1'b1);
        step(4'b1000, 1'b0, "arm_1000");
        step(4'b1000, 1'b0, "arm_1000");
        check_eq("arm_y_1000", bus_a.Y, 1'b0);

        // Sticky: every output inverted regardless of input.
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            step(v, 1'b0, "sticky");
            step(4'b0110, 1'b0, "sticky_sep");
            check_eq("sticky_inv", bus_a.Y, ~truth_tab[k]);
        end

        step(4'b0000, 1'b1, "rearm_rst");
        check_eq("rst1_y", bus_a.Y, 1'b0);
        check_eq("rst1_idle", dut.armed_s, 1'b0);
        step(4'b1000, 1'b0, "post_rst");
        step(4'b1000, 1'b0, "post_rst");
        check_eq("post_rst_1000", bus_a.Y, 1'b1);

        // TRIG_LEN=1: a single matching sample arms.
        step(4'b0000, 1'b1, "l1_rst");
        step(4'b1111, 1'b0, "l1_one");
        step(4'b0000, 1'b0, "l1_after");
        check_eq("l1_armed", dut1.armed_s, 1'b1);
        check_eq("l1_y_first", bus_b.Y, 1'b1);
        step(4'b0000, 1'b0, "l1_after");
        check_eq("l1_y_inv", bus_b.Y, 1'b1);
        check_eq("l4_y_plain", bus_a.Y, 1'b0);

        // Random phase, biased toward the trigger pattern.
        for (int k = 0; k < 500; k++) begin
            v = ($urandom_range(0, 99) < 45) ? 4'b1111 : 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            step(v, r, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
